// File: rtl/vectadd_from_sw_data.sv
// ============================================================================
// Module   : vectadd_from_sw_data
// Brief    : Avalon-MM slave queueing 32-bit software writes into a FIFO
//            presented to the vectadd datapath on a valid/ready stream.
// Option   : define VECTADD_FROM_SW_OVF_IRQ_EN for sticky overflow + irq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vectadd_from_sw_data #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_port,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam logic [AW:0] c_FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_last_wr;

  logic        w_wr;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic        w_full;
  logic        w_empty;
  logic        w_ovf;
  logic        w_irq_en;
  logic [31:0] w_status;
  logic [31:0] w_rdata;

  assign w_wr       = chipselect & ~write_n;
  assign w_push_req = w_wr && (address == 2'd0);
  assign w_flush    = w_wr && (address == 2'd2) && writedata[0];
  assign w_full     = (r_count == c_FULL_COUNT);
  assign w_empty    = (r_count == '0);
  // Full is judged on the pre-cycle count, so a pop cannot make room for a same-cycle push.
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = out_valid & out_ready;

  assign out_valid  = ~w_empty;
  assign out_port   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_last_wr <= '0;
    end else begin
      if (w_push_req) r_last_wr <= writedata;
      if (w_push) r_mem[r_wr_ptr] <= writedata;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
        else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  always_comb begin
    w_status         = '0;
    w_status[0]      = w_empty;
    w_status[1]      = w_full;
    w_status[2]      = w_ovf;
    w_status[8+AW:8] = r_count;
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata = r_last_wr;
      2'd1:    w_rdata = w_status;
      2'd3:    w_rdata = {31'b0, w_irq_en};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rdata;
  end

`ifdef VECTADD_FROM_SW_OVF_IRQ_EN
  logic r_ovf;
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (address == 2'd3)) r_irq_en <= writedata[0];
      // Software clear wins over a dropped push in the same cycle.
      if (w_wr && (address == 2'd2) && writedata[1]) r_ovf <= 1'b0;
      else if (w_push_req && w_full)                 r_ovf <= 1'b1;
      r_irq <= r_ovf & r_irq_en;
    end
  end

  assign w_ovf    = r_ovf;
  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_ovf    = 1'b0;
  assign w_irq_en = 1'b0;
  assign irq      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vectadd_from_sw_data.sv
// ============================================================================
// Module   : tb_vectadd_from_sw_data
// Brief    : Self-checking bench for vectadd_from_sw_data with a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vectadd_from_sw_data;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  bit live = 1'b0;

  vectadd_from_sw_data #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
  );

  always #5 clk = ~clk;

`ifdef VECTADD_FROM_SW_OVF_IRQ_EN
  localparam bit c_MACRO = 1'b1;
`else
  localparam bit c_MACRO = 1'b0;
`endif

  // Reference model: software-visible state kept as a queue and scalars.
  logic [31:0] m_q[$];
  logic [31:0] m_last;
  logic [31:0] m_rd;
  bit          m_ovf;
  bit          m_en;
  bit          m_irq;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_q.delete();
      m_last = '0;
      m_rd   = '0;
      m_ovf  = 1'b0;
      m_en   = 1'b0;
      m_irq  = 1'b0;
    end else begin
      bit was_full;
      bit wr;
      was_full = (m_q.size() == DEPTH);
      wr       = chipselect && !write_n;
      case (address)
        2'd0: m_rd = m_last;
        2'd1: m_rd = (m_q.size() << 8) | (int'(m_ovf) << 2) | (int'(was_full) << 1)
                     | int'(m_q.size() == 0);
        2'd2: m_rd = 0;
        default: m_rd = {31'b0, m_en};
      endcase
      m_irq = c_MACRO && m_ovf && m_en;
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (wr && address == 2'd0) begin
        m_last = writedata;
        if (!was_full) m_q.push_back(writedata);
        else if (c_MACRO) m_ovf = 1'b1;
      end
      if (wr && address == 2'd2) begin
        if (writedata[0]) m_q.delete();
        if (writedata[1]) m_ovf = 1'b0;
      end
      if (wr && address == 2'd3 && c_MACRO) m_en = writedata[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("model_out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) chk("model_out_port", out_port, m_q[0]);
      chk("model_readdata", readdata, m_rd);
      chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    @(negedge clk);
    chk(name, readdata, exp);
  endtask

  initial begin
    idle(3);
    reset_n = 1'b1;
    live = 1'b1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_out_port", out_port, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    rd(2'd1, 32'h0000_0001, "rst_status");

    // Single word.
    wr(2'd0, 32'hA5A5_0001);
    chk("one_out_valid", {31'b0, out_valid}, 32'd1);
    chk("one_out_port", out_port, 32'hA5A5_0001);
    rd(2'd1, 32'h0000_0100, "one_status");
    rd(2'd0, 32'hA5A5_0001, "one_last_wr");
    wr(2'd2, 32'h1);
    chk("flush_one", {31'b0, out_valid}, 32'd0);

    // Overfill, then same-cycle push of 9 with a pop while full.
    for (int i = 1; i <= 5; i++) wr(2'd0, i);
    rd(2'd1, c_MACRO ? 32'h0000_0406 : 32'h0000_0402, "full_status");
    rd(2'd0, 32'd5, "dropped_last_wr");
    out_ready = 1'b1;
    wr(2'd0, 32'd9);
    out_ready = 1'b0;
    chk("full_pop_head", out_port, 32'd2);
    rd(2'd1, c_MACRO ? 32'h0000_0304 : 32'h0000_0300, "full_pop_status");
    wr(2'd2, 32'h2);
    out_ready = 1'b1;
    idle(3);
    chk("drained", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Push and pop in the same cycle while not full.
    wr(2'd0, 32'h11);
    out_ready = 1'b1;
    wr(2'd0, 32'h22);
    out_ready = 1'b0;
    chk("pushpop_head", out_port, 32'h22);
    rd(2'd1, 32'h0000_0100, "pushpop_status");
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;

    // Pointer wrap with alternating push/pop.
    for (int i = 0; i < 10; i++) begin
      wr(2'd0, 32'h100 + i);
      chk("wrap_head", out_port, 32'h100 + i);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
    end
    rd(2'd1, 32'h0000_0001, "wrap_status");

    // Ignored write and zero register.
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0000_0001, "addr1_ignored");
    rd(2'd2, 32'h0, "addr2_zero");

    // Overflow interrupt path.
    wr(2'd3, 32'h1);
    rd(2'd3, c_MACRO ? 32'h1 : 32'h0, "irq_en_read");
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h200 + i);
    idle(1);
    chk("irq_set", {31'b0, irq}, c_MACRO ? 32'd1 : 32'd0);
    wr(2'd2, 32'h2);
    idle(1);
    chk("irq_clear", {31'b0, irq}, 32'd0);

    // Flush with three words queued.
    wr(2'd2, 32'h1);
    for (int i = 0; i < 3; i++) wr(2'd0, 32'h300 + i);
    rd(2'd1, 32'h0000_0300, "three_status");
    wr(2'd2, 32'h1);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    rd(2'd1, 32'h0000_0001, "flush_status");
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vectadd_from_sw_data.md
# vectadd_from_sw_data

Avalon-MM slave that carries 32-bit words from software into the vectadd datapath. It is the write-direction counterpart of the `vectadd_to_sw_data` input port. Processor writes are queued in a small FIFO and presented to hardware on a valid/ready stream. Status and control registers give software flow control (count/full/empty) and a flush.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO depth in words; power of two, 2..256.
- `AW`, default 2: log2(`DEPTH`); count width is `AW`+1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `address`  in  2  Avalon word address.
- `chipselect`  in  1  Avalon slave select.
- `write_n`  in  1  Avalon write strobe, active-low; write occurs when `chipselect`=1 and `write_n`=0.
- `writedata`  in  32  Avalon write data.
- `readdata`  out  32  registered read data, reset 0.
- `out_port`  out  32  FIFO head word, reset 0 (don't-care while `out_valid`=0, but driven from storage).
- `out_valid`  out  1  head word valid (= FIFO not empty), reset 0.
- `out_ready`  in  1  hardware accepts head word.
- `irq`  out  1  overflow interrupt, reset 0; tied 0 without `VECTADD_FROM_SW_OVF_IRQ_EN`.

## Operation
- Register map, writes:
  - addr 0 DATA: push `writedata` if FIFO not full; also latch into `last_wr` (latched even if the push is dropped).
  - addr 2 CTRL: bit0=1 flush FIFO (count←0, pointers←0); bit1=1 clear overflow flag.
  - addr 3 IRQ_EN: bit0 = irq enable (macro only; otherwise ignored).
  - addr 1: write ignored.
- Register map, reads:
  - addr 0: `last_wr`.
  - addr 1 STATUS: bit0 empty, bit1 full, bit2 overflow, bits[8+AW:8] count, other bits 0.
  - addr 2: 0.
  - addr 3: {31'b0, irq_en}.
- Read mux has no read strobe: `readdata` ← mux(`address`) every cycle, same as the input port.
- FIFO is circular: write/read pointers are `AW` bits and wrap from `DEPTH`-1 to 0; count is 0..`DEPTH`.
- Pop occurs when `out_valid`=1 and `out_ready`=1; head advances, count decrements.
- Push when full: word dropped, count unchanged; sets overflow flag (macro only).
- Push and pop same cycle, not full: both occur, count unchanged.
- Push and pop same cycle, full: push dropped (full is evaluated on pre-cycle count); pop proceeds.
- Flush plus pop, or flush plus push, in the same cycle: impossible in one Avalon write (flush and push use different addresses); flush and pop same cycle → flush wins, count=0.
- Reset clears pointers, count, `last_wr`, overflow, irq_en, `readdata`; FIFO storage contents need not be cleared.

## Timing
- Write at edge N → count/`out_valid`/`out_port` updated after edge N (visible in cycle N+1).
- Read latency 1: `address` sampled at edge N → `readdata` valid after edge N.
- STATUS read in the same cycle as a push returns the pre-push values.
- `out_port` reflects the new head in the cycle after a pop; no bubble when the FIFO stays non-empty, so back-to-back pops run at 1 word/cycle.
- Avalon write wait-states: none; `waitrequest` is not used.

## Configuration
- `VECTADD_FROM_SW_OVF_IRQ_EN` defined:
  - Sticky overflow flag set on dropped push; cleared by CTRL bit1 (clear wins over a same-cycle set).
  - IRQ_EN register present.
  - `irq` = overflow & irq_en, registered, asserted the cycle after the flag sets.
- Undefined:
  - STATUS bit2 reads 0; addr 3 reads 0; `irq` constant 0; dropped pushes are silent.

## Test plan
- Reset then read addr 1 → `readdata`=0x00000001 (empty); `out_valid`=0; `irq`=0.
- Write 0xA5A5_0001 to addr 0, `out_ready`=0 → next cycle `out_valid`=1, `out_port`=0xA5A50001; STATUS count=1; addr 0 reads 0xA5A50001.
- `DEPTH`=4: write 5 words 1..5 with `out_ready`=0 → STATUS full=1, count=4, overflow=1 (macro); then `out_ready`=1 → `out_port` sequence 1,2,3,4 on consecutive cycles, then `out_valid`=0.
- Full FIFO, same-cycle write 9 and pop → count stays 3 after pop, 9 never appears at `out_port`.
- Write pointer wrap: 10 alternating push/pop pairs → every word out equals word in, in order; count returns to 0.
- Macro on: IRQ_EN=1, overflow → `irq`=1; CTRL write 0x2 → `irq`=0 next cycle. Flush via CTRL 0x1 with 3 words queued → `out_valid`=0 next cycle, count=0.
